// File: rtl/usb_trn_control.sv
// usb_trn_control: USB device transaction sequencer (endpoint select, DATA0/DATA1 toggles, handshake/IN-data decisions).
// Latency: token or end-of-data strobe to request/pulse is one cycle; requests are held until tx_done_i.
// Backpressure: decoder strobes are never stalled; the transmitter paces via tx_done_i, host waits bounded by TIMEOUT.
module usb_trn_control #(
  parameter int NUM_EP  = 4,
  parameter int TIMEOUT = 96
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              trn_start_i,
  input  logic [1:0]        trn_type_i,
  input  logic [3:0]        trn_endpoint_i,
  input  logic              rx_trn_end_i,
  input  logic [1:0]        rx_trn_type_i,
  input  logic              crc_err_i,
  input  logic              trn_hsk_recv_i,
  input  logic [1:0]        trn_hsk_type_i,
  input  logic [NUM_EP-1:0] ep_ready_i,
  input  logic [NUM_EP-1:0] ep_has_data_i,
  input  logic [NUM_EP-1:0] ep_stall_i,
  output logic [3:0]        ep_sel_o,
  output logic              out_commit_o,
  output logic              out_discard_o,
  output logic              in_done_o,
  output logic              in_retry_o,
  output logic              tx_hsk_req_o,
  output logic [1:0]        tx_hsk_type_o,
  output logic              tx_data_req_o,
  output logic [1:0]        tx_data_pid_o,
  input  logic              tx_done_i
);

  localparam int          EPW        = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam logic [4:0]  NUM_EP_W   = 5'(NUM_EP);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] TOK_IN    = 2'b10;
  localparam logic [1:0] TOK_SETUP = 2'b11;
  localparam logic [1:0] TOK_RSVD  = 2'b01;
  localparam logic [1:0] HSK_ACK   = 2'b00;
  localparam logic [1:0] HSK_NAK   = 2'b10;
  localparam logic [1:0] HSK_STALL = 2'b11;
  localparam logic [1:0] PID_DATA0 = 2'b00;
  localparam logic [1:0] PID_DATA1 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_SEND_HSK, S_SEND_DATA, S_WAIT_HSK
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        ep_sel_q;
  logic              setup_q, setup_d;
  logic [1:0]        hsk_type_q, hsk_type_d;
  logic [15:0]       timer_q;
  logic [NUM_EP-1:0] out_tog_q, in_tog_q;
  logic              commit_q, commit_d, discard_q, discard_d;
  logic              done_q, done_d, retry_q, retry_d;
  logic              load_ep, setup_tog_set, out_tog_flip, in_tog_flip;
  logic [EPW-1:0]    cur_idx, tok_idx;
  logic              tok_ep_ok, timeout_hit;
  logic [1:0]        exp_pid;

  assign cur_idx     = ep_sel_q[EPW-1:0];
  assign tok_idx     = trn_endpoint_i[EPW-1:0];
  assign tok_ep_ok   = ({1'b0, trn_endpoint_i} < NUM_EP_W);
  assign timeout_hit = (timer_q == TIMER_LAST);
  assign exp_pid     = out_tog_q[cur_idx] ? PID_DATA1 : PID_DATA0;

  // State register; reset drops straight back to IDLE from anywhere.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and transaction outcome decisions.
  always_comb begin
    state_d       = state_q;
    setup_d       = setup_q;
    hsk_type_d    = hsk_type_q;
    commit_d      = 1'b0;
    discard_d     = 1'b0;
    done_d        = 1'b0;
    retry_d       = 1'b0;
    load_ep       = 1'b0;
    setup_tog_set = 1'b0;
    out_tog_flip  = 1'b0;
    in_tog_flip   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trn_start_i && tok_ep_ok && (trn_type_i != TOK_RSVD)) begin
          load_ep = 1'b1;
          setup_d = (trn_type_i == TOK_SETUP);
          if (trn_type_i != TOK_IN) begin
            state_d = S_WAIT_DATA;
          end else if (ep_stall_i[tok_idx]) begin
            state_d    = S_SEND_HSK;
            hsk_type_d = HSK_STALL;
          end else if (!ep_has_data_i[tok_idx]) begin
            state_d    = S_SEND_HSK;
            hsk_type_d = HSK_NAK;
          end else begin
            state_d = S_SEND_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (trn_start_i) begin
          // A new token abandons the transaction silently.
          state_d = S_IDLE;
        end else if (rx_trn_end_i) begin
          state_d = S_IDLE;
          if (crc_err_i) begin
            discard_d = 1'b1;
          end else if (setup_q) begin
            // SETUP is always accepted on DATA0 and resets both toggles to 1.
            if (rx_trn_type_i == PID_DATA0) begin
              state_d       = S_SEND_HSK;
              hsk_type_d    = HSK_ACK;
              commit_d      = 1'b1;
              setup_tog_set = 1'b1;
            end else begin
              discard_d = 1'b1;
            end
          end else if (ep_stall_i[cur_idx]) begin
            state_d    = S_SEND_HSK;
            hsk_type_d = HSK_STALL;
            discard_d  = 1'b1;
          end else if (rx_trn_type_i != exp_pid) begin
            // Retransmission of a packet already taken: ACK it again, drop the copy.
            state_d    = S_SEND_HSK;
            hsk_type_d = HSK_ACK;
            discard_d  = 1'b1;
          end else if (!ep_ready_i[cur_idx]) begin
            state_d    = S_SEND_HSK;
            hsk_type_d = HSK_NAK;
            discard_d  = 1'b1;
          end else begin
            state_d      = S_SEND_HSK;
            hsk_type_d   = HSK_ACK;
            commit_d     = 1'b1;
            out_tog_flip = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_SEND_HSK: begin
        if (tx_done_i) state_d = S_IDLE;
      end
      S_SEND_DATA: begin
        if (tx_done_i) state_d = S_WAIT_HSK;
      end
      S_WAIT_HSK: begin
        if (trn_start_i) begin
          state_d = S_IDLE;
          retry_d = 1'b1;
        end else if (trn_hsk_recv_i) begin
          state_d = S_IDLE;
          if (trn_hsk_type_i == HSK_ACK) begin
            done_d      = 1'b1;
            in_tog_flip = 1'b1;
          end else begin
            retry_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          retry_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction context, wait timer, toggles and one-cycle pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ep_sel_q   <= '0;
      setup_q    <= 1'b0;
      hsk_type_q <= '0;
      timer_q    <= '0;
      out_tog_q  <= '0;
      in_tog_q   <= '0;
      commit_q   <= 1'b0;
      discard_q  <= 1'b0;
      done_q     <= 1'b0;
      retry_q    <= 1'b0;
    end else begin
      commit_q   <= commit_d;
      discard_q  <= discard_d;
      done_q     <= done_d;
      retry_q    <= retry_d;
      setup_q    <= setup_d;
      hsk_type_q <= hsk_type_d;
      if (load_ep) ep_sel_q <= trn_endpoint_i;
      if (state_d != state_q)    timer_q <= '0;
      else if (timer_q != 16'hFFFF) timer_q <= timer_q + 16'd1;
      if (setup_tog_set) begin
        out_tog_q[cur_idx] <= 1'b1;
        in_tog_q[cur_idx]  <= 1'b1;
      end
      if (out_tog_flip) out_tog_q[cur_idx] <= ~out_tog_q[cur_idx];
      if (in_tog_flip)  in_tog_q[cur_idx]  <= ~in_tog_q[cur_idx];
    end
  end

  // Transmitter requests follow the state; PID tracks the selected EP's IN toggle.
  always_comb begin
    tx_hsk_req_o  = (state_q == S_SEND_HSK);
    tx_data_req_o = (state_q == S_SEND_DATA);
    tx_hsk_type_o = hsk_type_q;
    tx_data_pid_o = in_tog_q[cur_idx] ? PID_DATA1 : PID_DATA0;
  end

  assign ep_sel_o      = ep_sel_q;
  assign out_commit_o  = commit_q;
  assign out_discard_o = discard_q;
  assign in_done_o     = done_q;
  assign in_retry_o    = retry_q;

endmodule
